// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package sub_pkg;

   localparam int NIBBLE = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } sub_state_t;

endpackage

// File: rtl/nibble_serial_subtractor_slice.sv
// Combinational 4-bit carry-lookahead slice: every carry is derived directly from
// generate/propagate terms and cin, with no ripple between bit positions.
module cla_nibble_slice
   import sub_pkg::*;
(
   input  logic [NIBBLE-1:0] a,
   input  logic [NIBBLE-1:0] b,
   input  logic              cin,
   output logic [NIBBLE-1:0] sum,
   output logic              cout
);

   logic [NIBBLE-1:0] g;
   logic [NIBBLE-1:0] p;
   logic [NIBBLE:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

   assign sum  = p ^ c[NIBBLE-1:0];
   assign cout = c[NIBBLE];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, evaluated as a + ~b + ~bin one nibble
// per clock through a single CLA slice, with valid/ready handshakes on both sides.
module nibble_serial_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int N  = WIDTH / NIBBLE;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   sub_state_t       state_reg, state_next;
   logic [KW-1:0]    k_reg, k_next;
   logic [WIDTH-1:0] a_reg, a_next;
   logic [WIDTH-1:0] b_reg, b_next;
   logic             carry_reg, carry_next;
   logic [WIDTH-1:0] diff_reg, diff_next;
   logic             bout_reg, bout_next;
   logic             ovf_reg, ovf_next;

   logic [NIBBLE-1:0] a_nib [N];
   logic [NIBBLE-1:0] nb_nib [N];
   logic [NIBBLE-1:0] slice_a, slice_b, slice_sum;
   logic              slice_cout;

   // Split the operands into nibbles; the subtrahend is inverted here once.
   for (genvar gi = 0; gi < N; gi++) begin : g_nib
      assign a_nib[gi]  = a_reg[gi*NIBBLE +: NIBBLE];
      assign nb_nib[gi] = ~b_reg[gi*NIBBLE +: NIBBLE];
   end

   always_comb begin
      slice_a = '0;
      slice_b = '0;
      for (int i = 0; i < N; i++) begin
         if (k_reg == KW'(i)) begin
            slice_a = a_nib[i];
            slice_b = nb_nib[i];
         end
      end
   end

   cla_nibble_slice u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_reg),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         k_reg     <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         carry_reg <= 1'b0;
         diff_reg  <= '0;
         bout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         k_reg     <= k_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         carry_reg <= carry_next;
         diff_reg  <= diff_next;
         bout_reg  <= bout_next;
         ovf_reg   <= ovf_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      k_next     = k_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      carry_next = carry_reg;
      diff_next  = diff_reg;
      bout_next  = bout_reg;
      ovf_next   = ovf_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               a_next     = a;
               b_next     = b;
               carry_next = ~bin;
               k_next     = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            for (int i = 0; i < N; i++) begin
               if (k_reg == KW'(i)) begin
                  diff_next[i*NIBBLE +: NIBBLE] = slice_sum;
               end
            end
            carry_next = slice_cout;
            k_next     = k_reg + 1'b1;
            // Last nibble: the final carry is the inverted borrow, and signed
            // overflow compares the result sign against the minuend sign.
            if (k_reg == K_LAST) begin
               state_next = DONE;
               k_next     = '0;
               bout_next  = ~slice_cout;
               ovf_next   = (a_reg[WIDTH-1] != b_reg[WIDTH-1])
                          & (slice_sum[NIBBLE-1] != a_reg[WIDTH-1]);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_reg == IDLE);
      out_valid = (state_reg == DONE);
   end

   assign diff = diff_reg;
   assign bout = bout_reg;
   assign ovf  = ovf_reg;

endmodule
